// File: rtl/ptw_arbiter.sv
// Shared page-table-walk controller: round-robin arbitration between itlb and dtlb
// misses, a fixed-latency walk, and a one-cycle registered response pulse.
module ptw_arbiter #(
  parameter int WIDTH = 20,
  parameter int DELAY = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             itlb_req,
  input  logic [WIDTH-1:0] itlb_vpage,
  input  logic             dtlb_req,
  input  logic [WIDTH-1:0] dtlb_vpage,
  output logic             itlb_resp_valid,
  output logic             dtlb_resp_valid,
  output logic [WIDTH-1:0] resp_ppage,
  output logic             resp_exception,
  output logic             busy
);

  localparam int CNT_W = (DELAY > 1) ? $clog2(DELAY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DELAY - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [WIDTH-1:0] PAGE_ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] PAGE_ONE  = WIDTH'(1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WALK = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic GRANT_I = 1'b0;
  localparam logic GRANT_D = 1'b1;

  logic [1:0]       state_r, state_nxt_s;
  logic [CNT_W-1:0] counter_r, counter_nxt_s;
  logic             last_grant_r, last_grant_nxt_s;
  logic             grant_id_r, grant_id_nxt_s;
  logic [WIDTH-1:0] vpage_r, vpage_nxt_s;
  logic             pick_s;
  logic             walk_done_s;
  logic [WIDTH:0]   xlate_s;

  // Result is {exception, ppage}; page 0 faults, everything else maps to vpage+1 with wrap.
  function automatic logic [WIDTH:0] translate(input logic [WIDTH-1:0] vpage);
    logic [WIDTH:0] result;
    if (vpage == PAGE_ZERO) begin
      result = {1'b1, PAGE_ZERO};
    end else begin
      result = {1'b0, vpage + PAGE_ONE};
    end
    return result;
  endfunction

  // Round-robin pick: on a tie the requester that did not win last time is chosen.
  always_comb begin
    if (itlb_req && dtlb_req) begin
      pick_s = (last_grant_r == GRANT_I) ? GRANT_D : GRANT_I;
    end else if (dtlb_req) begin
      pick_s = GRANT_D;
    end else begin
      pick_s = GRANT_I;
    end
  end

  // Walk sequencing; request inputs are only looked at while idle.
  always_comb begin
    state_nxt_s      = state_r;
    counter_nxt_s    = counter_r;
    last_grant_nxt_s = last_grant_r;
    grant_id_nxt_s   = grant_id_r;
    vpage_nxt_s      = vpage_r;
    case (state_r)
      ST_IDLE: begin
        if (itlb_req || dtlb_req) begin
          state_nxt_s      = ST_WALK;
          counter_nxt_s    = CNT_LOAD;
          grant_id_nxt_s   = pick_s;
          last_grant_nxt_s = pick_s;
          vpage_nxt_s      = (pick_s == GRANT_D) ? dtlb_vpage : itlb_vpage;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_WALK: begin
        if (counter_r == CNT_ZERO) begin
          state_nxt_s = ST_RESP;
        end else begin
          counter_nxt_s = counter_r - CNT_ONE;
        end
      end
      ST_RESP: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  assign walk_done_s = (state_r == ST_WALK) && (counter_r == CNT_ZERO);
  assign xlate_s     = translate(vpage_r);

  // State registers; response outputs are loaded on the edge entering RESP so they are
  // registered and read as zero in every other cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r         <= ST_IDLE;
      counter_r       <= CNT_ZERO;
      last_grant_r    <= GRANT_I;
      grant_id_r      <= GRANT_I;
      vpage_r         <= PAGE_ZERO;
      itlb_resp_valid <= 1'b0;
      dtlb_resp_valid <= 1'b0;
      resp_ppage      <= PAGE_ZERO;
      resp_exception  <= 1'b0;
      busy            <= 1'b0;
    end else begin
      state_r         <= state_nxt_s;
      counter_r       <= counter_nxt_s;
      last_grant_r    <= last_grant_nxt_s;
      grant_id_r      <= grant_id_nxt_s;
      vpage_r         <= vpage_nxt_s;
      itlb_resp_valid <= walk_done_s && (grant_id_r == GRANT_I);
      dtlb_resp_valid <= walk_done_s && (grant_id_r == GRANT_D);
      resp_ppage      <= walk_done_s ? xlate_s[WIDTH-1:0] : PAGE_ZERO;
      resp_exception  <= walk_done_s && xlate_s[WIDTH];
      busy            <= (state_nxt_s != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_ptw_arbiter.sv
// Randomized scoreboard bench for ptw_arbiter: a timeline model predicts each response
// (who, when, what) and a negedge monitor compares whatever the DUT presents.
module tb_ptw_arbiter;
  localparam int WIDTH = 20;
  localparam int DELAY = 5;
  localparam int NCYC  = 3000;
  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

  logic             clk = 1'b0;
  logic             reset;
  logic             itlb_req, dtlb_req;
  logic [WIDTH-1:0] itlb_vpage, dtlb_vpage;
  logic             itlb_resp_valid, dtlb_resp_valid;
  logic [WIDTH-1:0] resp_ppage;
  logic             resp_exception;
  logic             busy;

  ptw_arbiter #(.WIDTH(WIDTH), .DELAY(DELAY)) dut (
    .clk(clk), .reset(reset),
    .itlb_req(itlb_req), .itlb_vpage(itlb_vpage),
    .dtlb_req(dtlb_req), .dtlb_vpage(dtlb_vpage),
    .itlb_resp_valid(itlb_resp_valid), .dtlb_resp_valid(dtlb_resp_valid),
    .resp_ppage(resp_ppage), .resp_exception(resp_exception), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int               edge_no;
    bit               is_d;
    logic [WIDTH-1:0] ppage;
    bit               exc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   edge_cnt = 0;
  int   m_free = 0;
  bit   m_last_d = 1'b0;
  int   m_busy_lo = -1;
  int   m_busy_hi = -1;
  bit   mon_on = 1'b0;

  // Reference model: one walk at a time, grant whenever free, response DELAY edges later.
  initial begin
    bit               pick_d;
    logic [WIDTH-1:0] v;
    exp_t             e;
    forever begin
      @(posedge clk);
      edge_cnt++;
      if (reset) begin
        exp_q.delete();
        m_free    = edge_cnt + 1;
        m_last_d  = 1'b0;
        m_busy_lo = -1;
        m_busy_hi = -1;
      end else if (edge_cnt >= m_free && (itlb_req || dtlb_req)) begin
        pick_d    = (itlb_req && dtlb_req) ? !m_last_d : dtlb_req;
        v         = pick_d ? dtlb_vpage : itlb_vpage;
        e.edge_no = edge_cnt + DELAY;
        e.is_d    = pick_d;
        e.exc     = (v == 0);
        e.ppage   = (v == 0) ? '0 : WIDTH'((longint'(v) + 1) % (longint'(1) << WIDTH));
        exp_q.push_back(e);
        m_last_d  = pick_d;
        m_busy_lo = edge_cnt;
        m_busy_hi = edge_cnt + DELAY;
        m_free    = edge_cnt + DELAY + 2;
      end
    end
  end

  // Monitor: compares outputs mid-cycle against the model's queue and busy window.
  initial begin
    exp_t e;
    bit   exp_busy;
    forever begin
      @(negedge clk);
      if (mon_on) begin
        exp_busy = (edge_cnt >= m_busy_lo) && (edge_cnt <= m_busy_hi) && (m_busy_lo >= 0);
        checks++;
        if (busy !== exp_busy) begin
          failures++;
          $display("FAIL busy edge=%0d got=%b exp=%b", edge_cnt, busy, exp_busy);
        end
        if (itlb_resp_valid === 1'b1 || dtlb_resp_valid === 1'b1) begin
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_resp edge=%0d i=%b d=%b exp=none", edge_cnt,
                     itlb_resp_valid, dtlb_resp_valid);
          end else begin
            e = exp_q.pop_front();
            if (e.edge_no != edge_cnt) begin
              failures++;
              $display("FAIL resp_time got_edge=%0d exp_edge=%0d", edge_cnt, e.edge_no);
            end
            checks++;
            if (itlb_resp_valid !== !e.is_d || dtlb_resp_valid !== e.is_d) begin
              failures++;
              $display("FAIL resp_id edge=%0d got i=%b d=%b exp_d=%b", edge_cnt,
                       itlb_resp_valid, dtlb_resp_valid, e.is_d);
            end
            checks++;
            if (resp_ppage !== e.ppage || resp_exception !== e.exc) begin
              failures++;
              $display("FAIL resp_data edge=%0d got ppage=%h exc=%b exp ppage=%h exc=%b",
                       edge_cnt, resp_ppage, resp_exception, e.ppage, e.exc);
            end
          end
        end else begin
          checks++;
          if (resp_ppage !== '0 || resp_exception !== 1'b0 ||
              itlb_resp_valid !== 1'b0 || dtlb_resp_valid !== 1'b0) begin
            failures++;
            $display("FAIL idle_outputs edge=%0d got ppage=%h exc=%b exp ppage=0 exc=0",
                     edge_cnt, resp_ppage, resp_exception);
          end
          if (exp_q.size() > 0 && exp_q[0].edge_no <= edge_cnt) begin
            e = exp_q.pop_front();
            checks++;
            failures++;
            $display("FAIL missed_resp edge=%0d got=none exp_edge=%0d exp_d=%b",
                     edge_cnt, e.edge_no, e.is_d);
          end
        end
      end
    end
  end

  // Stimulus: each TLB holds its miss until served, then waits a random gap.
  initial begin
    logic [WIDTH-1:0] i_dir[3];
    logic [WIDTH-1:0] d_dir[3];
    int i_idx = 0, d_idx = 0, i_wait = 0, d_wait = 0, r;
    i_dir[0] = WIDTH'(6);  i_dir[1] = ALL_ONES; i_dir[2] = WIDTH'(4);
    d_dir[0] = WIDTH'(9);  d_dir[1] = WIDTH'(0); d_dir[2] = WIDTH'(7);
    reset = 1'b1;
    itlb_req = 1'b0; dtlb_req = 1'b0;
    itlb_vpage = '0; dtlb_vpage = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    mon_on = 1'b1;
    for (int c = 0; c < NCYC; c++) begin
      @(posedge clk);
      #1;
      if (reset) reset = 1'b0;
      if (itlb_req && itlb_resp_valid) begin
        itlb_req = 1'b0;
        i_wait = $urandom_range(0, 6);
      end else if (!itlb_req) begin
        if (i_wait > 0) begin
          i_wait--;
          itlb_vpage = WIDTH'($urandom);
        end else begin
          itlb_req = 1'b1;
          r = $urandom_range(0, 9);
          if (i_idx < 3) itlb_vpage = i_dir[i_idx];
          else if (r == 0) itlb_vpage = '0;
          else if (r == 1) itlb_vpage = ALL_ONES;
          else itlb_vpage = WIDTH'($urandom);
          i_idx++;
        end
      end
      if (dtlb_req && dtlb_resp_valid) begin
        dtlb_req = 1'b0;
        d_wait = $urandom_range(0, 6);
      end else if (!dtlb_req) begin
        if (d_wait > 0) begin
          d_wait--;
          dtlb_vpage = WIDTH'($urandom);
        end else begin
          dtlb_req = 1'b1;
          r = $urandom_range(0, 9);
          if (d_idx < 3) dtlb_vpage = d_dir[d_idx];
          else if (r == 0) dtlb_vpage = '0;
          else if (r == 1) dtlb_vpage = ALL_ONES;
          else dtlb_vpage = WIDTH'($urandom);
          d_idx++;
        end
      end
      // Occasional reset mid-traffic; aborted requests are re-presented afterwards.
      if (c == 45 || (c > 100 && $urandom_range(0, 149) == 0)) begin
        reset = 1'b1;
        itlb_req = 1'b0;
        dtlb_req = 1'b0;
        i_wait = $urandom_range(0, 3);
        d_wait = $urandom_range(0, 3);
      end
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    itlb_req = 1'b0;
    dtlb_req = 1'b0;
    repeat (DELAY + 4) @(posedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain outstanding=%0d exp=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ptw_arbiter.md
Name: ptw_arbiter

Overview:
- Shared page-table-walk (PTW) controller that services TLB misses from two requesters: the instruction-side TLB (itlb) and the data-side TLB (dtlb).
- Arbitrates between the two miss requests and sequences a fixed-latency walk.
- Returns the translated physical page, or a page-fault exception, to the winning requester as a one-cycle response pulse.
- Sits between the TLBs and the memory-side walk resource; only one walk is ever in flight.

Parameters:
- WIDTH, 20, page number width in bits (virtual and physical).
- DELAY, 5, walk latency in cycles; legal range is DELAY >= 1.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  reset; synchronous and active-high.
- itlb_req  in  1  itlb miss request; level signal, held until served.
- itlb_vpage  in  WIDTH  virtual page of the itlb miss; stable while itlb_req is high.
- dtlb_req  in  1  dtlb miss request; level signal, held until served.
- dtlb_vpage  in  WIDTH  virtual page of the dtlb miss; stable while dtlb_req is high.
- itlb_resp_valid  out  1  one-cycle pulse: walk for itlb complete.
- dtlb_resp_valid  out  1  one-cycle pulse: walk for dtlb complete.
- resp_ppage  out  WIDTH  translated physical page; valid only while a resp_valid is high.
- resp_exception  out  1  page fault; valid only while a resp_valid is high.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (synchronous, active-high):
  - state = IDLE; counter = 0; last_grant = I.
  - All outputs 0.
  - Asserting reset mid-walk or in RESP aborts the walk: no response pulse is issued and the request is dropped. The requester re-presents it after reset.
- FSM states: IDLE, WALK, RESP.
- IDLE:
  - No request pending: stay in IDLE.
  - Any request pending: grant one requester, latch its vpage and id, load counter = DELAY-1, go to WALK.
- Arbitration:
  - Single requester: granted immediately.
  - Both requesters: grant the one that is not last_grant (round-robin); update last_grant on every grant.
  - After reset, last_grant = I, so the first tie goes to dtlb.
- WALK:
  - Decrement counter each cycle.
  - When counter == 0, go to RESP.
  - Request inputs are ignored; changes on the non-granted port have no effect on the walk in flight.
- RESP (exactly one cycle):
  - Assert the granted requester's resp_valid only; the other resp_valid stays 0.
  - Drive resp_ppage and resp_exception from the latched vpage (rules below).
  - Go to IDLE unconditionally.
- Latency: request sampled in IDLE in cycle t → resp_valid in cycle t+DELAY+1; busy high for cycles t+1 .. t+DELAY+1.
- Back-to-back: the next IDLE cycle (t+DELAY+2) can grant the waiting requester. Minimum spacing between consecutive responses is DELAY+2 cycles.
- Handshake: the served requester must have its req low by the cycle after its resp_valid, unless it is issuing a new miss. A req still high in that IDLE cycle is treated as a new miss.
- Translation rule:
  - resp_ppage = latched_vpage + 1, computed modulo 2^WIDTH; all-ones wraps to 0 with no exception.
  - latched_vpage == 0 → resp_exception = 1 and resp_ppage = 0.
- Outputs outside RESP: resp_ppage = 0 and resp_exception = 0 (no stale data).
- The counter is sized to hold DELAY-1. DELAY = 1 gives exactly one WALK cycle.

Test Plan (DELAY=5, WIDTH=20, cycle 0 = first cycle after reset deasserted):
1. itlb_req=1, itlb_vpage=2 in cycle 0 → itlb_resp_valid=1 only in cycle 6, resp_ppage=3, resp_exception=0, dtlb_resp_valid=0 throughout; busy high in cycles 1–6.
2. dtlb_req=1, dtlb_vpage=0 in cycle 0 → dtlb_resp_valid=1 in cycle 6, resp_exception=1, resp_ppage=0.
3. itlb_vpage=6 and dtlb_vpage=9, both requested in cycle 0 and held → dtlb served first: cycle 6, resp_ppage=10. Then itlb: cycle 13, resp_ppage=7. Next tie after that goes to dtlb.
4. itlb_vpage=0xFFFFF → cycle 6: resp_ppage=0x00000, resp_exception=0.
5. itlb_req with vpage=4 in cycle 0, reset=1 in cycle 3 → cycle 4: all outputs 0, busy=0, no resp pulse ever. Re-request after reset drops → response 6 cycles later with resp_ppage=5.
6. dtlb_req held continuously with vpage=7, itlb idle → dtlb_resp_valid pulses in cycles 6, 13, 20, each with resp_ppage=8; outputs are 0 in all non-RESP cycles.
